// File: rtl/regfile_pkg.sv
// Shared constants and small helpers for the register file and its write arbiter.
// Imported by the interface, the round-robin grant logic and the arbiter top.
package regfile_pkg;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 2;
  localparam int NUM_REGS = 3;
  localparam int NUM_REQ  = 3;
  localparam int CNT_W    = 8;

  localparam logic [ADDR_W-1:0] BAD_ADDR = 2'b11;

  typedef enum logic [1:0] {
    PTR_0 = 2'd0,
    PTR_1 = 2'd1,
    PTR_2 = 2'd2
  } rr_ptr_e;

  // Priority pointer position following a grant to requester idx (mod 3).
  function automatic rr_ptr_e ptr_after(input logic [1:0] idx);
    rr_ptr_e nxt;
    case (idx)
      2'd0:    nxt = PTR_1;
      2'd1:    nxt = PTR_2;
      2'd2:    nxt = PTR_0;
      default: nxt = PTR_0;
    endcase
    return nxt;
  endfunction

  function automatic logic [1:0] onehot3_to_idx(input logic [2:0] oh);
    logic [1:0] idx;
    case (oh)
      3'b001:  idx = 2'd0;
      3'b010:  idx = 2'd1;
      3'b100:  idx = 2'd2;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Request and register-file write bundle between the requesters and the write arbiter.
// Requester i uses address bits [2i+1:2i] and data bits [DATA_W*i +: DATA_W].
interface regfile_write_arbiter_if #(
  parameter int DATA_W  = 8,
  parameter int NUM_REQ = 3
) ();

  logic [NUM_REQ-1:0]        req_valid;
  logic [2*NUM_REQ-1:0]      req_addr;
  logic [DATA_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      write_enable;
  logic [1:0]                write_address;
  logic [DATA_W-1:0]         write_data;
  logic                      err_bad_addr;
  logic [7:0]                write_count;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready,
    input  write_enable,
    input  write_address,
    input  write_data,
    input  err_bad_addr,
    input  write_count
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready,
    output write_enable,
    output write_address,
    output write_data,
    output err_bad_addr,
    output write_count
  );

endinterface

// File: rtl/rr_arbiter3.sv
// Three-way round-robin grant: one-hot grant to the first valid requester
// searching from ptr upwards (mod 3); all zero when nothing is valid.
module rr_arbiter3
  import regfile_pkg::*;
(
  input  logic [2:0]        valid,
  input  logic [ADDR_W-1:0] ptr,
  output logic [2:0]        grant
);

  logic [2:0] rot_s;
  logic [2:0] pick_s;

  function automatic logic [2:0] pick_first(input logic [2:0] v);
    logic [2:0] r;
    if (v[0]) begin
      r = 3'b001;
    end else if (v[1]) begin
      r = 3'b010;
    end else if (v[2]) begin
      r = 3'b100;
    end else begin
      r = 3'b000;
    end
    return r;
  endfunction

  // Rotate so the pointed requester sits at bit 0, pick, then rotate back.
  always_comb begin
    rot_s  = valid;
    pick_s = 3'b000;
    grant  = 3'b000;
    case (ptr)
      2'd1: begin
        rot_s  = {valid[0], valid[2], valid[1]};
        pick_s = pick_first(rot_s);
        grant  = {pick_s[1], pick_s[0], pick_s[2]};
      end
      2'd2: begin
        rot_s  = {valid[1], valid[0], valid[2]};
        pick_s = pick_first(rot_s);
        grant  = {pick_s[0], pick_s[2], pick_s[1]};
      end
      default: begin
        rot_s  = valid;
        pick_s = pick_first(rot_s);
        grant  = pick_s;
      end
    endcase
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin write arbiter in front of a 3-entry register file: accepts one
// request per cycle and issues a registered write strobe, address and data.
module regfile_write_arbiter #(
  parameter int DATA_W  = regfile_pkg::DATA_W,
  parameter int NUM_REQ = regfile_pkg::NUM_REQ
) (
  input  logic                    clk,
  input  logic                    reset,
  regfile_write_arbiter_if.slave  bus
);

  import regfile_pkg::*;

  logic [NUM_REQ-1:0] grant_s;
  logic [NUM_REQ-1:0] ready_s;
  logic               xfer_s;
  logic [1:0]         grant_idx_s;
  logic [ADDR_W-1:0]  sel_addr_s;
  logic [DATA_W-1:0]  sel_data_s;
  rr_ptr_e            ptr_r;
  rr_ptr_e            ptr_nxt_s;

  logic               we_r;
  logic [ADDR_W-1:0]  waddr_r;
  logic [DATA_W-1:0]  wdata_r;
  logic               err_r;
  logic [CNT_W-1:0]   cnt_r;

  rr_arbiter3 u_rr (
    .valid (bus.req_valid),
    .ptr   (ptr_r),
    .grant (grant_s)
  );

  // Grants are suppressed for the whole cycle while reset is held low.
  always_comb begin
    ready_s = '0;
    if (reset) begin
      ready_s = grant_s;
    end else begin
      ready_s = '0;
    end
  end

  // Transfer detection and selection of the granted requester's address/data.
  always_comb begin
    xfer_s      = |(bus.req_valid & ready_s);
    grant_idx_s = onehot3_to_idx(ready_s);
    sel_addr_s  = '0;
    sel_data_s  = '0;
    case (grant_idx_s)
      2'd0: begin
        sel_addr_s = bus.req_addr[1:0];
        sel_data_s = bus.req_data[DATA_W-1:0];
      end
      2'd1: begin
        sel_addr_s = bus.req_addr[3:2];
        sel_data_s = bus.req_data[2*DATA_W-1:DATA_W];
      end
      2'd2: begin
        sel_addr_s = bus.req_addr[5:4];
        sel_data_s = bus.req_data[3*DATA_W-1:2*DATA_W];
      end
      default: begin
        sel_addr_s = '0;
        sel_data_s = '0;
      end
    endcase
  end

  // Pointer next state: move past the winner on a transfer, otherwise hold.
  always_comb begin
    ptr_nxt_s = ptr_r;
    if (xfer_s) begin
      ptr_nxt_s = ptr_after(grant_idx_s);
    end else begin
      ptr_nxt_s = ptr_r;
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_r <= PTR_0;
    end else begin
      ptr_r <= ptr_nxt_s;
    end
  end

  // Write-side registers; a bad-address transfer is consumed without a write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      we_r    <= 1'b0;
      waddr_r <= '0;
      wdata_r <= '0;
      err_r   <= 1'b0;
      cnt_r   <= '0;
    end else if (xfer_s) begin
      if (sel_addr_s == BAD_ADDR) begin
        we_r  <= 1'b0;
        err_r <= 1'b1;
      end else begin
        we_r    <= 1'b1;
        waddr_r <= sel_addr_s;
        wdata_r <= sel_data_s;
        cnt_r   <= cnt_r + 8'd1;
      end
    end else begin
      we_r <= 1'b0;
    end
  end

  assign bus.req_ready     = ready_s;
  assign bus.write_enable  = we_r;
  assign bus.write_address = waddr_r;
  assign bus.write_data    = wdata_r;
  assign bus.err_bad_addr  = err_r;
  assign bus.write_count   = cnt_r;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a
// cycle-level behavioural model of the round-robin write arbiter.
module tb_regfile_write_arbiter;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  regfile_write_arbiter_if #(.DATA_W(8), .NUM_REQ(3)) bus ();

  regfile_write_arbiter #(.DATA_W(8), .NUM_REQ(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // model state (values the DUT should show after the most recent edge)
  int m_ptr;
  bit m_we;
  int m_wa;
  int m_wd;
  bit m_err;
  int m_cnt;
  bit m_known = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [2:0] model_grant(input logic [2:0] v, input logic rst);
    logic [2:0] r;
    r = 3'b000;
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        int idx;
        idx = (m_ptr + k) % 3;
        if (v[idx] && r == 3'b000) r[idx] = 1'b1;
      end
    end
    return r;
  endfunction

  // One cycle: drive inputs after the falling edge, check, then advance the model.
  task automatic step(input logic [2:0] v, input logic [5:0] a, input logic [23:0] d, input logic rst);
    logic [2:0] g;
    int gi;
    @(negedge clk);
    reset         = rst;
    bus.req_valid = v;
    bus.req_addr  = a;
    bus.req_data  = d;
    #1;
    g = model_grant(v, rst);
    check_eq("req_ready", {29'd0, bus.req_ready}, {29'd0, g});
    if (m_known) begin
      check_eq("write_enable", {31'd0, bus.write_enable}, {31'd0, m_we});
      check_eq("write_address", {30'd0, bus.write_address}, m_wa);
      check_eq("write_data", {24'd0, bus.write_data}, m_wd);
      check_eq("err_bad_addr", {31'd0, bus.err_bad_addr}, {31'd0, m_err});
      check_eq("write_count", {24'd0, bus.write_count}, m_cnt);
    end
    if (!rst) begin
      m_ptr = 0; m_we = 1'b0; m_wa = 0; m_wd = 0; m_err = 1'b0; m_cnt = 0;
      m_known = 1'b1;
    end else if (g != 3'b000) begin
      gi = (g == 3'b001) ? 0 : (g == 3'b010) ? 1 : 2;
      m_ptr = (gi + 1) % 3;
      if (a[2*gi +: 2] == 2'b11) begin
        m_we  = 1'b0;
        m_err = 1'b1;
      end else begin
        m_we  = 1'b1;
        m_wa  = a[2*gi +: 2];
        m_wd  = d[8*gi +: 8];
        m_cnt = (m_cnt + 1) % 256;
      end
    end else begin
      m_we = 1'b0;
    end
  endtask

  task automatic idle(input logic rst);
    step(3'b000, 6'd0, 24'd0, rst);
  endtask

  initial begin
    logic [2:0]  rv;
    logic [5:0]  ra;
    logic [23:0] rd;
    logic        rr;

    reset = 1'b0;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;

    // reset state, then a single request from requester 0
    idle(1'b0);
    idle(1'b0);
    step(3'b001, 6'b00_00_00, 24'h00_00_01, 1'b1);
    idle(1'b1);
    check_eq("single_count", {24'd0, bus.write_count}, 32'd1);

    // fairness: all three valid for six cycles from ptr=0
    idle(1'b0);
    for (int i = 0; i < 6; i++) step(3'b111, 6'b10_01_00, 24'h12_11_10, 1'b1);
    idle(1'b1);
    check_eq("fair_count", {24'd0, bus.write_count}, 32'd6);

    // bad address from requester 1, then a good write from requester 0
    idle(1'b0);
    step(3'b010, 6'b00_11_00, 24'h00_AA_00, 1'b1);
    check_eq("bad_no_we", {31'd0, bus.write_enable}, 32'd0);
    step(3'b001, 6'b00_00_01, 24'h00_00_55, 1'b1);
    idle(1'b1);
    check_eq("bad_sticky", {31'd0, bus.err_bad_addr}, 32'd1);
    check_eq("bad_count", {24'd0, bus.write_count}, 32'd1);

    // counter wrap: 256 writes from requester 2
    idle(1'b0);
    for (int i = 0; i < 256; i++) step(3'b100, 6'b10_00_00, 24'h5A_00_00, 1'b1);
    idle(1'b1);
    check_eq("wrap_count", {24'd0, bus.write_count}, 32'd0);

    // reset mid-stream with ptr=2 and requesters 0 and 2 valid
    idle(1'b0);
    step(3'b010, 6'b00_01_00, 24'h00_33_00, 1'b1);
    step(3'b101, 6'b10_00_00, 24'h44_00_22, 1'b0);
    step(3'b101, 6'b10_00_00, 24'h44_00_22, 1'b1);
    idle(1'b1);

    // idle hold after writing FF to address 2
    idle(1'b0);
    step(3'b100, 6'b10_00_00, 24'hFF_00_00, 1'b1);
    for (int i = 0; i < 5; i++) idle(1'b1);
    check_eq("hold_addr", {30'd0, bus.write_address}, 32'd2);
    check_eq("hold_data", {24'd0, bus.write_data}, 32'hFF);
    step(3'b111, 6'b10_01_00, 24'h03_02_01, 1'b1);

    // random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      rv = 3'($urandom);
      ra = 6'($urandom);
      rd = 24'($urandom);
      rr = ($urandom_range(0, 39) != 0);
      step(rv, ra, rd, rr);
    end
    idle(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
